// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver: majority-voted bit decisions, optional parity,
// 1 or 2 stop bits, and a small receive FIFO with overrun reporting.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a 1->0 edge; tick accumulator held at 0
// S_START     | voting the start bit; a 1 vote is treated as a glitch
// S_DATA      | capturing DATA_BITS bits, LSB first
// S_PARITY    | capturing the parity bit
// S_STOP      | voting stop bits; frame pushed after the last stop vote
// S_WAIT_IDLE | framing error with line still low; wait for line high
module uart_rx_framed #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int MID    = OVERSAMPLE / 2;
    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [31:0]      ACC_INC  = 32'(BAUD_RATE * OVERSAMPLE);
    localparam logic [31:0]      ACC_MOD  = 32'(CLK_FREQ);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t state;

    // Synchroniser plus one extra stage for falling-edge detection
    logic sync1, line, line_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rx_pin;
            line      <= sync1;
            line_prev <= line;
        end
    end

    // Fractional tick generator; remainder carried so there is no drift
    logic [31:0] acc;
    logic [31:0] acc_sum;
    logic        tick;

    assign acc_sum = acc + ACC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (state == S_IDLE) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (acc_sum >= ACC_MOD) begin
            acc  <= acc_sum - ACC_MOD;
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum;
            tick <= 1'b0;
        end
    end

    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 s0, s1;
    logic                 vote;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit;
    logic                 ferr_acc;
    logic                 push_req;
    logic [WORD_W-1:0]    push_word;
    logic                 par_x;
    logic                 perr_calc;

    assign vote  = (s0 & s1) | (s0 & line) | (s1 & line);
    assign par_x = ^{shreg, pbit};

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY == 1)
            perr_calc = ~par_x;
        else if (PARITY == 2)
            perr_calc = par_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            shreg     <= '0;
            pbit      <= 1'b0;
            ferr_acc  <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            push_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (line_prev && !line) begin
                        state    <= S_START;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                S_WAIT_IDLE: begin
                    if (line)
                        state <= S_IDLE;
                end
                default: begin
                    if (tick) begin
                        if (cnt == CNT_S0)
                            s0 <= line;
                        if (cnt == CNT_S1)
                            s1 <= line;
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;

                        if (cnt == CNT_VOTE) begin
                            case (state)
                                S_START: begin
                                    if (vote)
                                        state <= S_IDLE;
                                end
                                S_DATA:   shreg <= {vote, shreg[DATA_BITS-1:1]};
                                S_PARITY: pbit  <= vote;
                                S_STOP: begin
                                    if (!vote)
                                        ferr_acc <= 1'b1;
                                    // Re-arm at the middle of the last stop bit
                                    if (stop_idx == STOP_LAST) begin
                                        push_req  <= 1'b1;
                                        push_word <= {perr_calc, ferr_acc | ~vote, shreg};
                                        state     <= vote ? S_IDLE : S_WAIT_IDLE;
                                    end
                                end
                                default: ;
                            endcase
                        end

                        if (cnt == CNT_LAST) begin
                            case (state)
                                S_START: state <= S_DATA;
                                S_DATA: begin
                                    if (bit_idx == BIT_LAST)
                                        state <= (PARITY != 0) ? S_PARITY : S_STOP;
                                    else
                                        bit_idx <= bit_idx + 4'd1;
                                end
                                S_PARITY: state    <= S_STOP;
                                S_STOP:   stop_idx <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    // Receive FIFO; extra pointer bit separates full from empty
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              empty, full, pop, push_ok;
    logic [WORD_W-1:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[PTR_W-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            overrun <= push_req && full && !pop;
        end
    end

    assign head     = mem[rd_ptr[PTR_W-1:0]];
    assign rx_valid = !empty;
    assign {rx_perr, rx_ferr, rx_data} = rx_valid ? head : '0;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: an 8N1 instance and an 8E1 instance, 32 clk per bit.
module tb_uart_rx_framed;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_p;
    logic       rdy_a, rdy_p;
    logic [7:0] data_a, data_p;
    logic       perr_a, perr_p, ferr_a, ferr_p;
    logic       valid_a, valid_p, ovr_a, ovr_p, busy_a, busy_p;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_p = 0;
    bit auto_chk = 1'b0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_p[$];

    always #5 clk = ~clk;

    uart_rx_framed #(
        .CLK_FREQ(32_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_a), .rx_data(data_a),
        .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_valid(valid_a),
        .rx_ready(rdy_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_framed #(
        .CLK_FREQ(32_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_p), .rx_data(data_p),
        .rx_perr(perr_p), .rx_ferr(ferr_p), .rx_valid(valid_p),
        .rx_ready(rdy_p), .overrun(ovr_p), .busy(busy_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input int n);
        if (sel) rx_p = v; else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit pbit, input bit stop);
        drive(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
        if (sel) drive(sel, pbit, BIT_CLK);
        drive(sel, stop, BIT_CLK);
        drive(sel, 1'b1, 0);
    endtask

    task automatic pop_one(input bit sel);
        if (sel) rdy_p = 1'b1; else rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_p = 1'b0;
    endtask

    // Overrun pulse counters and the randomized consumer/scoreboard
    initial forever begin
        @(negedge clk);
        if (ovr_a) ovr_cnt_a++;
        if (ovr_p) ovr_cnt_p++;
        if (auto_chk) begin
            rdy_a = 1'($urandom_range(0, 1));
            rdy_p = 1'($urandom_range(0, 1));
            if (valid_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_a_extra: got %0h expected no entry", {perr_a, ferr_a, data_a});
                end else
                    check("rand_a", 32'({perr_a, ferr_a, data_a}), 32'(exp_a.pop_front()));
            end
            if (valid_p && rdy_p) begin
                if (exp_p.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_p_extra: got %0h expected no entry", {perr_p, ferr_p, data_p});
                end else
                    check("rand_p", 32'({perr_p, ferr_p, data_p}), 32'(exp_p.pop_front()));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         pbit;
        bit         stop;
        logic [7:0] exp_d;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit sel, busy_drop, pb, st;
        logic [7:0] d;
        int wait_cnt;

        vecs[0] = '{0, 8'hA5, 0, 1, 8'hA5, 0, 0};
        vecs[1] = '{0, 8'h00, 0, 1, 8'h00, 0, 0};
        vecs[2] = '{0, 8'hFF, 0, 1, 8'hFF, 0, 0};
        vecs[3] = '{0, 8'h3C, 0, 0, 8'h3C, 0, 1};
        vecs[4] = '{1, 8'h03, 1, 1, 8'h03, 1, 0};
        vecs[5] = '{1, 8'h03, 0, 1, 8'h03, 0, 0};
        vecs[6] = '{1, 8'h80, 1, 1, 8'h80, 0, 0};
        vecs[7] = '{1, 8'h55, 1, 0, 8'h55, 1, 1};

        rst_n = 1'b0; rx_a = 1'b1; rx_p = 1'b1; rdy_a = 1'b0; rdy_p = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_ovr", 32'(ovr_a), 0);
        check("rst_word", 32'({perr_a, ferr_a, data_a}), 0);
        check("rst_valid_p", 32'(valid_p), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Directed frames with the push timing window around the stop bit
        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].sel;
            drive(sel, 1'b0, BIT_CLK);
            for (int i = 0; i < 8; i++) drive(sel, vecs[v].d[i], BIT_CLK);
            if (sel) drive(sel, vecs[v].pbit, BIT_CLK);
            drive(sel, vecs[v].stop, 14);
            check($sformatf("vec%0d_valid_early", v), 32'(sel ? valid_p : valid_a), 0);
            drive(sel, vecs[v].stop, BIT_CLK - 14);
            check($sformatf("vec%0d_valid", v), 32'(sel ? valid_p : valid_a), 1);
            drive(sel, 1'b1, 4);
            check($sformatf("vec%0d_data", v), 32'(sel ? data_p : data_a), 32'(vecs[v].exp_d));
            check($sformatf("vec%0d_perr", v), 32'(sel ? perr_p : perr_a), 32'(vecs[v].exp_perr));
            check($sformatf("vec%0d_ferr", v), 32'(sel ? ferr_p : ferr_a), 32'(vecs[v].exp_ferr));
            pop_one(sel);
            check($sformatf("vec%0d_empty", v), 32'(sel ? valid_p : valid_a), 0);
            repeat (8) @(negedge clk);
        end

        // Line held low for 20 bit times
        busy_drop = 1'b0;
        rx_a = 1'b0;
        for (int i = 0; i < 20 * BIT_CLK; i++) begin
            @(negedge clk);
            if (i >= 8 && !busy_a) busy_drop = 1'b1;
        end
        check("break_busy_held", 32'(busy_drop), 0);
        check("break_valid", 32'(valid_a), 1);
        check("break_word", 32'({perr_a, ferr_a, data_a}), 32'h100);
        rx_a = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_release", 32'(busy_a), 0);
        repeat (100) @(negedge clk);
        pop_one(0);
        check("break_single_entry", 32'(valid_a), 0);

        // 10-clk glitch on an idle line
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_rise", 32'(busy_a), 1);
        rx_a = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("glitch_busy_fall", 32'(busy_a), 0);
        repeat (400) @(negedge clk);
        check("glitch_no_entry", 32'(valid_a), 0);

        // FIFO overrun with the consumer stalled
        ovr_cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            send_frame(0, 8'(8'h11 + i), 0, 1);
            drive(0, 1'b1, 4);
        end
        check("ovr_none_yet", 32'(ovr_cnt_a), 0);
        send_frame(0, 8'h15, 0, 1);
        drive(0, 1'b1, 10);
        check("ovr_once", 32'(ovr_cnt_a), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr_pop%0d", i), 32'(data_a), 32'(8'h11 + i));
            pop_one(0);
        end
        check("ovr_drained", 32'(valid_a), 0);

        // Reset in the middle of data bit 3 with an entry already queued
        send_frame(0, 8'hE7, 0, 1);
        drive(0, 1'b1, 4);
        check("pre_rst_valid", 32'(valid_a), 1);
        drive(0, 1'b0, BIT_CLK);
        drive(0, 1'b1, BIT_CLK);
        drive(0, 1'b1, BIT_CLK);
        drive(0, 1'b0, BIT_CLK);
        drive(0, 1'b0, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_valid", 32'(valid_a), 0);
        check("mid_rst_word", 32'({perr_a, ferr_a, data_a}), 0);
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_idle", 32'(valid_a), 0);
        send_frame(0, 8'h5A, 0, 1);
        drive(0, 1'b1, 10);
        check("post_rst_valid", 32'(valid_a), 1);
        check("post_rst_data", 32'(data_a), 32'h5A);
        pop_one(0);
        check("post_rst_single", 32'(valid_a), 0);

        // Randomized frames against the scoreboard
        ovr_cnt_a = 0;
        ovr_cnt_p = 0;
        auto_chk = 1'b1;
        for (int n = 0; n < 24; n++) begin
            sel = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            pb  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 5) != 0);
            if (sel) exp_p.push_back({^{d, pb}, ~st, d});
            else     exp_a.push_back({1'b0, ~st, d});
            send_frame(sel, d, pb, st);
            drive(sel, 1'b1, $urandom_range(4, 40));
        end
        wait_cnt = 0;
        while ((exp_a.size() != 0 || exp_p.size() != 0) && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        auto_chk = 1'b0;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_p = 1'b0;
        check("rand_drain_a", 32'(exp_a.size()), 0);
        check("rand_drain_p", 32'(exp_p.size()), 0);
        check("rand_no_ovr", 32'(ovr_cnt_a + ovr_cnt_p), 0);
        repeat (4) @(negedge clk);
        check("rand_final_empty", 32'({valid_a, valid_p}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line bit rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal values are even and 8..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-005 SHALL have parameter PARITY, default 0, where 0=none, 1=odd, 2=even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, range 2..16.
REQ-008 SHALL have port clk, input, 1 bit, rising-edge system clock.
REQ-009 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port rx_pin, input, 1 bit, asynchronous serial line that idles high.
REQ-011 SHALL have port rx_data, output, DATA_BITS wide, data word at the FIFO head.
REQ-012 SHALL have port rx_perr, output, 1 bit, parity-error flag of the head entry.
REQ-013 SHALL have port rx_ferr, output, 1 bit, framing-error flag of the head entry.
REQ-014 SHALL have port rx_valid, output, 1 bit, high when the FIFO is not empty.
REQ-015 SHALL have port rx_ready, input, 1 bit; the consumer pops the head when rx_valid and rx_ready are both high on a clk edge.
REQ-016 SHALL have port overrun, output, 1 bit, one-cycle pulse when a completed frame is dropped.
REQ-017 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL synchronise rx_pin through 2 flops that reset to 1; all logic SHALL use the synchronised signal only.
REQ-019 SHALL generate the sample tick exactly with a 32-bit accumulator: add BAUD_RATE*OVERSAMPLE every clk; when the sum is >= CLK_FREQ, subtract CLK_FREQ and pulse tick for 1 clk, so there is no long-term drift.
REQ-020 SHALL hold the accumulator at 0 in IDLE and restart it on start-edge detection.
REQ-021 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-022 IDLE: a 1->0 transition of the synchronised line SHALL enter START with the sample-counter and bit index cleared.
REQ-023 Each bit SHALL be decided by a majority vote of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within that bit.
REQ-024 START: a vote of 1 SHALL count as a glitch and return to IDLE with nothing pushed; a vote of 0 SHALL enter DATA.
REQ-025 DATA: the FSM SHALL capture DATA_BITS bits LSB-first, one per OVERSAMPLE ticks, then go to PARITY if PARITY!=0, else to STOP.
REQ-026 PARITY: perr SHALL be 1 if the XOR of the data bits and the parity bit is 0 for odd parity, or 1 for even parity.
REQ-027 STOP: each of the STOP_BITS bits SHALL be voted; any stop vote of 0 SHALL set ferr.
REQ-028 The frame SHALL be pushed as {perr, ferr, data} on the clk after the final stop vote.
REQ-029 After the push the FSM SHALL go to IDLE if the last stop vote was 1, else to WAIT_IDLE.
REQ-030 WAIT_IDLE (break or low line) SHALL stay until the synchronised line is 1, then go to IDLE, so a held-low line gives exactly 1 frame.
REQ-031 STOP_BITS=2 SHALL not delay re-arming beyond the middle of the final stop bit.
REQ-032 rx_valid SHALL rise on the clk after a push into an empty FIFO.
REQ-033 rx_data, rx_perr and rx_ferr SHALL be stable while rx_valid=1 and no pop occurs.
REQ-034 Push while the FIFO is full and no pop occurs in the same cycle: the new frame SHALL be dropped, FIFO contents left unchanged, and overrun pulsed for 1 clk.
REQ-035 Push and pop in the same cycle SHALL both take effect, including when full, with no overrun.
REQ-036 A pop while rx_valid=0 SHALL be ignored.
REQ-037 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-038 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-039 rst_n low SHALL asynchronously force the FSM to IDLE, clear the accumulator, counters, bit index and FIFO pointers, and set the synchroniser flops to 1.
REQ-040 During reset, rx_valid=0, overrun=0 and busy=0; rx_data, rx_perr and rx_ferr SHALL read 0.
REQ-041 Reset in mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh 1->0 edge.

Verification (CLK_FREQ=32_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16, so tick every 2 clk and 32 clk per bit)
REQ-042 Send 8N1 byte 0xA5 -> exactly one entry, rx_data=0xA5, perr=0, ferr=0, rx_valid high within 2 clk of the stop-bit vote.
REQ-043 PARITY=2, send 0x03 with parity bit 1 -> perr=1; resend with parity bit 0 -> perr=0.
REQ-044 Hold the line low for 20 bit times -> one entry with rx_data=0x00 and ferr=1; busy stays high until the line returns high; no second entry.
REQ-045 Apply a 10-clk low glitch on an idle line -> no entry, busy returns to 0 within 1 bit time.
REQ-046 FIFO_DEPTH=4 with rx_ready=0, send 5 bytes 0x11..0x15 -> one overrun pulse on byte 5; pops return 0x11, 0x12, 0x13, 0x14.
REQ-047 Assert rst_n low during data bit 3 of a frame, then send 0x5A -> only 0x5A received.
